// File: rtl/wisc_mem_pkg.sv
// rtl/wisc_mem_pkg.sv - shared state encoding and sizing helpers for mem_stage
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    ERR    = 2'b10
  } mem_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute, data-memory and writeback signals of mem_stage
interface mem_stage_if;
  logic        ex_valid;
  logic [15:0] ex_result;
  logic [15:0] ex_store_data;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_reg_wr_en;
  logic [2:0]  ex_reg_wr_sel;
  logic        ex_halt;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [15:0] dmem_rdata;
  logic        dmem_done;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        wb_reg_wr_en;
  logic [2:0]  wb_reg_wr_sel;
  logic        wb_halt;
  logic        err;

  modport slave (
    input  ex_valid, ex_result, ex_store_data, ex_mem_rd, ex_mem_wr,
           ex_reg_wr_en, ex_reg_wr_sel, ex_halt, dmem_rdata, dmem_done,
    output dmem_addr, dmem_wdata, dmem_rd, dmem_wr, stall, wb_valid,
           wb_data, wb_reg_wr_en, wb_reg_wr_sel, wb_halt, err
  );

  modport master (
    output ex_valid, ex_result, ex_store_data, ex_mem_rd, ex_mem_wr,
           ex_reg_wr_en, ex_reg_wr_sel, ex_halt, dmem_rdata, dmem_done,
    input  dmem_addr, dmem_wdata, dmem_rd, dmem_wr, stall, wb_valid,
           wb_data, wb_reg_wr_en, wb_reg_wr_sel, wb_halt, err
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - access wait counter with clear, enable and terminal count
module mem_timeout_cnt #(
  parameter int          W    = 4,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == LAST);
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage FSM with dmem handshake and timeout;
// defining MEM_ALIGN_CHECK_EN traps odd load/store addresses into ERR.
module mem_stage
  import wisc_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  localparam int             CW   = clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        is_rd_q, is_rd_d, is_wr_q, is_wr_d;
  logic        p_en_q, p_en_d, p_halt_q, p_halt_d;
  logic [2:0]  p_sel_q, p_sel_d;
  logic        wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, wb_halt_q, wb_halt_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  wb_sel_q, wb_sel_d;
  logic        err_q, err_d;
  logic        cnt_clr, cnt_en, cnt_tc, mem_op, misaligned;

  assign mem_op = bus.ex_mem_rd | bus.ex_mem_wr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = bus.ex_result[0];
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_cnt #(.W(CW), .LAST(LAST)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_rd_d    = is_rd_q;
    is_wr_d    = is_wr_q;
    p_en_d     = p_en_q;
    p_sel_d    = p_sel_q;
    p_halt_d   = p_halt_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_en_d    = wb_en_q;
    wb_sel_d   = wb_sel_q;
    wb_halt_d  = wb_halt_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        wb_valid_d = 1'b0;
        if (bus.ex_valid && mem_op && misaligned) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (bus.ex_valid && mem_op) begin
          // Writeback controls are parked until the access completes.
          addr_d   = bus.ex_result;
          wdata_d  = bus.ex_store_data;
          is_rd_d  = bus.ex_mem_rd;
          is_wr_d  = bus.ex_mem_wr;
          p_en_d   = bus.ex_reg_wr_en;
          p_sel_d  = bus.ex_reg_wr_sel;
          p_halt_d = bus.ex_halt;
          cnt_clr  = 1'b1;
          state_d  = ACCESS;
        end else if (bus.ex_valid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = bus.ex_result;
          wb_en_d    = bus.ex_reg_wr_en;
          wb_sel_d   = bus.ex_reg_wr_sel;
          wb_halt_d  = bus.ex_halt;
        end
      end
      ACCESS: begin
        cnt_en = 1'b1;
        // Done is checked first so a completion on the last allowed cycle wins.
        if (bus.dmem_done) begin
          wb_valid_d = 1'b1;
          wb_data_d  = is_rd_q ? bus.dmem_rdata : addr_q;
          wb_en_d    = p_en_q;
          wb_sel_d   = p_sel_q;
          wb_halt_d  = p_halt_q;
          state_d    = IDLE;
        end else if (cnt_tc) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      ERR: begin
        wb_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_rd_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      p_en_q     <= 1'b0;
      p_sel_q    <= '0;
      p_halt_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_en_q    <= 1'b0;
      wb_sel_q   <= '0;
      wb_halt_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_rd_q    <= is_rd_d;
      is_wr_q    <= is_wr_d;
      p_en_q     <= p_en_d;
      p_sel_q    <= p_sel_d;
      p_halt_q   <= p_halt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_en_q    <= wb_en_d;
      wb_sel_q   <= wb_sel_d;
      wb_halt_q  <= wb_halt_d;
      err_q      <= err_d;
    end
  end

  assign bus.dmem_addr     = addr_q;
  assign bus.dmem_wdata    = wdata_q;
  assign bus.dmem_rd       = (state_q == ACCESS) && is_rd_q;
  assign bus.dmem_wr       = (state_q == ACCESS) && is_wr_q;
  assign bus.stall         = (state_q == ACCESS) || (state_q == ERR);
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_reg_wr_en  = wb_en_q;
  assign bus.wb_reg_wr_sel = wb_sel_q;
  assign bus.wb_halt       = wb_halt_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - cycle-by-cycle vector table plus a bounded load sequence for mem_stage
module tb_mem_stage;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic        rst, v;
    logic [15:0] res, sd;
    logic        rd, wr, en;
    logic [2:0]  sel;
    logic        halt, done;
    logic [15:0] rdata;
    logic        e_wbv;
    logic [15:0] e_wbd;
    logic        e_en;
    logic [2:0]  e_sel;
    logic        e_halt, e_stall, e_rd, e_wr;
    logic [15:0] e_addr, e_wdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(
    input logic rst_i, v, input logic [15:0] res, sd, input logic rd, wr, en,
    input logic [2:0] sel, input logic halt, done, input logic [15:0] rdata,
    input logic e_wbv, input logic [15:0] e_wbd, input logic e_en,
    input logic [2:0] e_sel, input logic e_halt, e_stall, e_rd, e_wr,
    input logic [15:0] e_addr, e_wdata, input logic e_err);
    vec_t t;
    t.rst = rst_i; t.v = v; t.res = res; t.sd = sd; t.rd = rd; t.wr = wr; t.en = en;
    t.sel = sel; t.halt = halt; t.done = done; t.rdata = rdata;
    t.e_wbv = e_wbv; t.e_wbd = e_wbd; t.e_en = e_en; t.e_sel = e_sel; t.e_halt = e_halt;
    t.e_stall = e_stall; t.e_rd = e_rd; t.e_wr = e_wr; t.e_addr = e_addr;
    t.e_wdata = e_wdata; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_i, v, input logic [15:0] res, sd, input logic rd, wr, en,
                       input logic [2:0] sel, input logic halt, done, input logic [15:0] rdata);
    rst = rst_i;
    bus_if.ex_valid = v; bus_if.ex_result = res; bus_if.ex_store_data = sd;
    bus_if.ex_mem_rd = rd; bus_if.ex_mem_wr = wr; bus_if.ex_reg_wr_en = en;
    bus_if.ex_reg_wr_sel = sel; bus_if.ex_halt = halt;
    bus_if.dmem_done = done; bus_if.dmem_rdata = rdata;
  endtask

  initial begin
    int cyc;
    int stalls;
    drive(H, L, 16'h0, 16'h0, L, L, L, 3'd0, L, L, 16'h0);
    //  rst v  res       sd        rd wr en sel   hlt done rdata   | wbv wbd      en sel   hlt stl rd wr addr      wdata     err
    add(H, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0000, L, 3'd0, L, L, L, L, 16'h0000, 16'h0000, L);
    add(L, H, 16'h1234, 16'h0000, L, L, H, 3'd3, L, L, 16'h0000,   H, 16'h1234, H, 3'd3, L, L, L, L, 16'h0000, 16'h0000, L);
    add(L, H, 16'h0042, 16'h0000, L, L, H, 3'd5, L, L, 16'h0000,   H, 16'h0042, H, 3'd5, L, L, L, L, 16'h0000, 16'h0000, L);
    add(L, L, 16'hFFFF, 16'h0000, L, L, H, 3'd7, L, L, 16'h0000,   L, 16'h0042, H, 3'd5, L, L, L, L, 16'h0000, 16'h0000, L);
    // load 0x0010, done on the third ACCESS cycle; ex_* noise while stalled
    add(L, H, 16'h0010, 16'h1111, H, L, H, 3'd2, L, L, 16'h0000,   L, 16'h0042, H, 3'd5, L, H, H, L, 16'h0010, 16'h1111, L);
    add(L, H, 16'h9999, 16'h0000, L, L, H, 3'd7, L, L, 16'hDEAD,   L, 16'h0042, H, 3'd5, L, H, H, L, 16'h0010, 16'h1111, L);
    add(L, H, 16'h9999, 16'h0000, L, H, H, 3'd7, L, L, 16'h0000,   L, 16'h0042, H, 3'd5, L, H, H, L, 16'h0010, 16'h1111, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, H, 16'hBEEF,   H, 16'hBEEF, H, 3'd2, L, L, L, L, 16'h0010, 16'h1111, L);
    // store 0xCAFE at 0x0020, done in IDLE ignored, completes after 1 cycle
    add(L, H, 16'h0020, 16'hCAFE, L, H, L, 3'd0, L, H, 16'h0000,   L, 16'hBEEF, H, 3'd2, L, H, L, H, 16'h0020, 16'hCAFE, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, H, 16'h0000,   H, 16'h0020, L, 3'd0, L, L, L, L, 16'h0020, 16'hCAFE, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0020, L, 3'd0, L, L, L, L, 16'h0020, 16'hCAFE, L);
    add(L, H, 16'h00AA, 16'h0000, L, L, L, 3'd1, H, L, 16'h0000,   H, 16'h00AA, L, 3'd1, H, L, L, L, 16'h0020, 16'hCAFE, L);
    // load 0x0030, done on the 4th (last allowed) ACCESS cycle
    add(L, H, 16'h0030, 16'h0000, H, L, H, 3'd4, L, L, 16'h0000,   L, 16'h00AA, L, 3'd1, H, H, H, L, 16'h0030, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h00AA, L, 3'd1, H, H, H, L, 16'h0030, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h00AA, L, 3'd1, H, H, H, L, 16'h0030, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h00AA, L, 3'd1, H, H, H, L, 16'h0030, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, H, 16'h5A5A,   H, 16'h5A5A, H, 3'd4, L, L, L, L, 16'h0030, 16'h0000, L);
    // store aborted by reset in its 2nd ACCESS cycle
    add(L, H, 16'h0040, 16'h7777, L, H, L, 3'd0, L, L, 16'h0000,   L, 16'h5A5A, H, 3'd4, L, H, L, H, 16'h0040, 16'h7777, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h5A5A, H, 3'd4, L, H, L, H, 16'h0040, 16'h7777, L);
    add(H, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, H, 16'h0000,   L, 16'h0000, L, 3'd0, L, L, L, L, 16'h0000, 16'h0000, L);
    add(L, H, 16'h0101, 16'h0000, L, L, H, 3'd6, L, L, 16'h0000,   H, 16'h0101, H, 3'd6, L, L, L, L, 16'h0000, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, H, 16'h3333,   L, 16'h0101, H, 3'd6, L, L, L, L, 16'h0000, 16'h0000, L);
    // load 0x0050 that times out after 4 ACCESS cycles; done in ERR ignored
    add(L, H, 16'h0050, 16'h0000, H, L, H, 3'd3, L, L, 16'h0000,   L, 16'h0101, H, 3'd6, L, H, H, L, 16'h0050, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0101, H, 3'd6, L, H, H, L, 16'h0050, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0101, H, 3'd6, L, H, H, L, 16'h0050, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0101, H, 3'd6, L, H, H, L, 16'h0050, 16'h0000, L);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0101, H, 3'd6, L, H, L, L, 16'h0050, 16'h0000, H);
    add(L, H, 16'h0000, 16'h0000, L, L, H, 3'd1, L, H, 16'hFFFF,   L, 16'h0101, H, 3'd6, L, H, L, L, 16'h0050, 16'h0000, H);
    add(H, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0000, L, 3'd0, L, L, L, L, 16'h0000, 16'h0000, L);
    // odd-address load: trapped when alignment checking is built in
    add(L, H, 16'h0011, 16'h0000, H, L, H, 3'd1, L, L, 16'h0000,
        L, 16'h0000, L, 3'd0, L, H, ~ALIGN, L, ALIGN ? 16'h0000 : 16'h0011, 16'h0000, ALIGN);
    add(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, H, 16'h1357,
        ~ALIGN, ALIGN ? 16'h0000 : 16'h1357, ~ALIGN, ALIGN ? 3'd0 : 3'd1, L, ALIGN, L, L,
        ALIGN ? 16'h0000 : 16'h0011, 16'h0000, ALIGN);
    add(H, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000,   L, 16'h0000, L, 3'd0, L, L, L, L, 16'h0000, 16'h0000, L);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].wr,
            vecs[i].en, vecs[i].sel, vecs[i].halt, vecs[i].done, vecs[i].rdata);
      @(posedge clk);
      #1;
      chk("wb_valid",      i, 16'(bus_if.wb_valid),      16'(vecs[i].e_wbv));
      chk("wb_data",       i, bus_if.wb_data,            vecs[i].e_wbd);
      chk("wb_reg_wr_en",  i, 16'(bus_if.wb_reg_wr_en),  16'(vecs[i].e_en));
      chk("wb_reg_wr_sel", i, 16'(bus_if.wb_reg_wr_sel), 16'(vecs[i].e_sel));
      chk("wb_halt",       i, 16'(bus_if.wb_halt),       16'(vecs[i].e_halt));
      chk("stall",         i, 16'(bus_if.stall),         16'(vecs[i].e_stall));
      chk("dmem_rd",       i, 16'(bus_if.dmem_rd),       16'(vecs[i].e_rd));
      chk("dmem_wr",       i, 16'(bus_if.dmem_wr),       16'(vecs[i].e_wr));
      chk("dmem_addr",     i, bus_if.dmem_addr,          vecs[i].e_addr);
      chk("dmem_wdata",    i, bus_if.dmem_wdata,         vecs[i].e_wdata);
      chk("err",           i, 16'(bus_if.err),           16'(vecs[i].e_err));
    end

    // Load 0x0060 with done after three cycles, waited on with a cycle budget.
    drive(L, H, 16'h0060, 16'h0000, H, L, H, 3'd7, L, L, 16'h0000);
    @(posedge clk);
    #1;
    drive(L, L, 16'h0000, 16'h0000, L, L, L, 3'd0, L, L, 16'h0000);
    cyc = 0;
    stalls = 0;
    while (!bus_if.wb_valid && cyc < 10) begin
      if (bus_if.stall) stalls++;
      if (cyc == 2) begin
        bus_if.dmem_done = H;
        bus_if.dmem_rdata = 16'h2468;
      end
      @(posedge clk);
      #1;
      bus_if.dmem_done = L;
      cyc++;
    end
    chk("seq_wb_valid_seen", 100, 16'(bus_if.wb_valid), 16'h0001);
    chk("seq_stall_cycles",  100, 16'(stalls),          16'd3);
    chk("seq_wb_data",       100, bus_if.wb_data,       16'h2468);
    chk("seq_wb_reg_wr_sel", 100, 16'(bus_if.wb_reg_wr_sel), 16'd7);
    chk("seq_stall_after",   100, 16'(bus_if.stall),    16'h0000);

    // Next instruction is accepted in the cycle the writeback is presented.
    drive(L, H, 16'h0BAD, 16'h0000, L, L, H, 3'd2, L, L, 16'h0000);
    @(posedge clk);
    #1;
    chk("seq_next_wb_valid", 101, 16'(bus_if.wb_valid), 16'h0001);
    chk("seq_next_wb_data",  101, bus_if.wb_data,       16'h0BAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the pipelined core, directly downstream of the execute stage. Latches the execute stage's ALU result, store data and register-write controls, and runs a request/done handshake with a multi-cycle data memory. It stalls upstream stages while an access is outstanding, and presents a one-cycle-per-instruction writeback bundle to the writeback stage. Misaligned accesses and memory timeouts are flagged on a sticky error.

## Interface
Parameters:
- TIMEOUT, default 16: maximum number of ACCESS cycles allowed without `dmem_done` before the block flags an error. Legal range is 2..255.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a valid instruction this cycle
- ex_result  in  16  ALU result; used as the memory address for loads and stores
- ex_store_data  in  16  store data (Rt value)
- ex_mem_rd  in  1  instruction is a load
- ex_mem_wr  in  1  instruction is a store; `ex_mem_rd` and `ex_mem_wr` are never both 1
- ex_reg_wr_en  in  1  instruction writes the register file
- ex_reg_wr_sel  in  3  destination register
- ex_halt  in  1  instruction is HALT
- dmem_addr  out  16  memory address
- dmem_wdata  out  16  memory write data
- dmem_rd  out  1  read request
- dmem_wr  out  1  write request
- dmem_rdata  in  16  read data; valid only in a cycle where `dmem_done`=1
- dmem_done  in  1  access completes this cycle
- stall  out  1  upstream stages must hold; `ex_*` inputs are ignored while high
- wb_valid  out  1  writeback bundle valid; one-cycle pulse per retired instruction
- wb_data  out  16  load data, or `ex_result` for every non-load instruction
- wb_reg_wr_en  out  1  registered copy of `ex_reg_wr_en`
- wb_reg_wr_sel  out  3  registered copy of `ex_reg_wr_sel`
- wb_halt  out  1  registered copy of `ex_halt`
- err  out  1  sticky error; cleared only by `rst`

## Operation
- State machine with three states: IDLE, ACCESS, ERR.
- **IDLE**, `ex_valid`=0: `wb_valid` goes to 0 at the next edge. No other outputs change.
- **IDLE**, `ex_valid`=1, non-memory instruction: at the edge, `wb_valid`=1, `wb_data`=`ex_result`, and the control fields are registered. State stays IDLE.
- **IDLE**, `ex_valid`=1, load or store:
  - At the edge, capture the address, store data, direction and all `wb_*` fields internally.
  - `wb_valid` goes to 0.
  - Clear the wait counter and go to ACCESS.
- **ACCESS**:
  - `dmem_rd`/`dmem_wr` are held high from the captured direction, with `dmem_addr`/`dmem_wdata` stable.
  - `stall`=1.
  - The wait counter increments every cycle.
- **ACCESS** with `dmem_done`=1: at the edge, `wb_valid`=1 and `wb_data` takes `dmem_rdata` for a load or the captured address for a store. State returns to IDLE.
- **ACCESS**, counter reaches TIMEOUT-1 with `dmem_done`=0: go to ERR and set `err`. No writeback occurs.
- **ERR**: `stall`=1, `dmem_rd`=`dmem_wr`=0, `wb_valid`=0. Terminal until `rst`.
- `stall` is combinational: 1 in ACCESS or ERR, 0 otherwise.
- Boundary cases:
  - `dmem_done` arriving in the same cycle the counter hits its limit: done wins and the access completes normally.
  - `dmem_done` while in IDLE or ERR: ignored.
  - `ex_*` changes during stall: ignored.
- Reset at any point, including mid-ACCESS: at that edge the state goes to IDLE and every output goes to 0. `dmem_rd`/`dmem_wr` are low from the next cycle, and no writeback is produced for the aborted access.

## Timing
- Reset value of every output is 0: `dmem_*`, `stall`, `wb_*`, `err`.
- Non-memory instruction: 1-cycle latency, one instruction per cycle.
- Memory instruction:
  - Accepted at edge t; requests are visible from cycle t+1.
  - If done arrives in cycle t+k (k≥1), `wb_valid` is high in cycle t+k+1.
  - `stall` is high in cycles t+1..t+k, and the next instruction is accepted at the end of cycle t+k+1.
- Timeout: err is set at the edge ending the TIMEOUT-th ACCESS cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a load or store with `ex_result[0]`=1 goes straight to ERR with `err`=1.
  - No memory request is issued.
- Not defined: bit 0 is not checked, and the address is forwarded unchanged.

## Structure
- Shared package `wisc_mem_pkg` holds:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, ERR=2'b10
  - default TIMEOUT
  - counter width function clog2(TIMEOUT)
- One sub-module, `mem_timeout_cnt`, with clear, enable and terminal-count output. The FSM and capture registers stay in `mem_stage`.

## Test plan
- Back-to-back ALU ops with `ex_result`=16'h1234 then 16'h0042 -> `wb_valid`=1 on two consecutive cycles with matching `wb_data`, and `stall`=0 throughout.
- Load at address 16'h0010, done after 3 cycles with `dmem_rdata`=16'hBEEF -> `stall` high for 3 cycles, `dmem_rd`=1 and `dmem_addr`=16'h0010 throughout, then `wb_data`=16'hBEEF with `wb_reg_wr_sel` preserved.
- Store of 16'hCAFE at address 16'h0020, done after 1 cycle -> `dmem_wr`=1 for exactly 1 cycle, `wb_data`=16'h0020, `wb_valid` 1 pulse.
- TIMEOUT=4, `dmem_done` never asserted -> `err`=1 after 4 ACCESS cycles, `stall` stays 1, no `wb_valid`; done arriving on the 4th cycle instead gives normal completion.
- Load at 16'h0011 -> with `MEM_ALIGN_CHECK_EN` defined, `err`=1 next cycle and no `dmem_rd`; without it, `dmem_rd`=1 and `dmem_addr`=16'h0011.
- `rst` asserted during the 2nd ACCESS cycle -> all outputs 0 next cycle, and the following ALU op retires normally.
